// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: muldiv bus; master drives start/op/a/b/hi_we/lo_we/wdata, slave returns busy/done/div_by_zero/hi/lo
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic hi_we;
  logic lo_we;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, hi_we, lo_we, wdata, input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-bit MIPS mul/div owning HI/LO; ports clk, rst (sync high), bus (slave: start/op/a/b/hi_we/lo_we/wdata in, busy/done/div_by_zero/hi/lo out)
module hilo_muldiv (
  input logic clk,
  input logic rst,
  hilo_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t st;
  logic [4:0] cnt;
  logic [1:0] opr;
  logic neg_q;
  logic neg_r;
  logic dz;
  logic [31:0] m;
  logic [31:0] orig_a;
  logic [63:0] p;
  logic sgn;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [32:0] sum;
  logic [32:0] shl;
  logic [32:0] diff;
  logic [63:0] prod;
  assign bus.busy = st != IDLE;
  always_comb begin
    sgn = ~bus.op[0];
    ma = (sgn & bus.a[31]) ? -bus.a : bus.a;
    mb = (sgn & bus.b[31]) ? -bus.b : bus.b;
    sum = {1'b0, p[63:32]} + {1'b0, p[0] ? m : 32'd0};
    shl = {p[63:32], p[31]};
    diff = shl - {1'b0, m};
    prod = neg_q ? -p : p;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      opr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      m <= '0;
      orig_a <= '0;
      p <= '0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
          if (bus.start) begin
            st <= RUN;
            cnt <= '0;
            opr <= bus.op;
            neg_q <= sgn & (bus.a[31] ^ bus.b[31]);
            neg_r <= sgn & bus.a[31];
            dz <= bus.op[1] & (bus.b == '0);
            orig_a <= bus.a;
            m <= bus.op[1] ? mb : ma;
            p <= {32'd0, bus.op[1] ? ma : mb};
          end
        end
        RUN: begin
          // divide: restoring step keeps the shifted remainder when the subtract borrows
          p <= opr[1] ? {diff[32] ? shl[31:0] : diff[31:0], p[30:0], ~diff[32]} : {sum, p[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) st <= FIX;
        end
        FIX: begin
          st <= IDLE;
          bus.done <= 1'b1;
          bus.div_by_zero <= dz;
          bus.hi <= !opr[1] ? prod[63:32] : dz ? orig_a : neg_r ? -p[63:32] : p[63:32];
          bus.lo <= !opr[1] ? prod[31:0] : dz ? 32'hFFFF_FFFF : neg_q ? -p[31:0] : p[31:0];
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench for hilo_muldiv
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hilo_muldiv_if bus();
  hilo_muldiv dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic dz;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    longint sa;
    longint sbv;
    longint q;
    longint r;
    if (!op[1]) begin
      ea = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
      eb = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
      return {1'b0, ea * eb};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op[0]) return {1'b0, a % b, a / b};
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    q = sa / sbv;
    r = sa % sbv;
    return {1'b0, r[31:0], q[31:0]};
  endfunction
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic we, logic [31:0] wd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.hi_we = we;
    bus.lo_we = we;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.op = 2'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask
  task automatic wait_done(int n0);
    int n = n0;
    exp_t e;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 33);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, bus.hi, e.hi);
      chk({e.tag, "_lo"}, bus.lo, e.lo);
      chk({e.tag, "_dz"}, 32'(bus.div_by_zero), 32'(e.dz));
      last_hi = e.hi;
      last_lo = e.lo;
    end
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask
  task automatic run_op(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el, logic edz);
    sb.push_back('{tag, eh, el, edz});
    issue(op, a, b, 1'b0, 32'd0);
    wait_done(0);
  endtask
  task automatic mt(logic hw, logic lw, logic [31:0] wd);
    @(negedge clk);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = wd;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask
  initial begin
    logic [64:0] mr;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int dones;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    mt(1'b1, 1'b0, 32'hA5A5_0001);
    chk("mthi_hi", bus.hi, 32'hA5A5_0001);
    chk("mthi_lo", bus.lo, 32'd0);
    mt(1'b0, 1'b1, 32'h5A5A_0002);
    chk("mtlo_hi", bus.hi, 32'hA5A5_0001);
    chk("mtlo_lo", bus.lo, 32'h5A5A_0002);
    mt(1'b1, 1'b1, 32'h0BAD_F00D);
    chk("mtboth_hi", bus.hi, 32'h0BAD_F00D);
    chk("mtboth_lo", bus.lo, 32'h0BAD_F00D);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 2'b00, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'd0, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    sb.push_back('{"guard", 32'd0, 32'd30, 1'b0});
    issue(2'b01, 32'd5, 32'd6, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    chk("guard_hi_mid", bus.hi, last_hi);
    chk("guard_lo_mid", bus.lo, last_lo);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("guard_busy", 32'(bus.busy), 32'd1);
    chk("guard_hi_we_ignored", bus.hi, last_hi);
    chk("guard_lo_held", bus.lo, last_lo);
    wait_done(4);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("guard_no_requeue", dones, 0);
    issue(2'b11, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op("divu_1000_3", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    sb.push_back('{"start_with_mt", 32'd2, 32'd3, 1'b0});
    issue(2'b11, 32'd20, 32'd6, 1'b1, 32'hDEAD_BEEF);
    chk("start_mt_hi", bus.hi, 32'hDEAD_BEEF);
    chk("start_mt_lo", bus.lo, 32'hDEAD_BEEF);
    wait_done(0);
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      mr = model(rop, ra, rb);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, mr[63:32], mr[31:0], mr[64]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
